// File: rtl/araddr_pkg.sv
// Shared definitions for the AXI read-address burst issuer: protocol constants,
// FSM state encoding and the per-burst beat-count helper.
package araddr_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int         AXI_BOUNDARY   = 4096;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ISSUE
  } state_t;

  // Largest legal burst: limited by remaining beats, the burst cap and the distance to the next 4 KB page.
  function automatic logic [8:0] f_burst_beats(input logic [31:0] rem,
                                               input logic [11:0] addr_lo,
                                               input int          max_burst,
                                               input int          size_log2);
    logic [12:0] room;
    logic [8:0]  beats;
    room = (13'(AXI_BOUNDARY) - {1'b0, addr_lo}) >> size_log2;
    if (rem > 32'(max_burst)) beats = 9'(max_burst);
    else                      beats = rem[8:0];
    if ({4'b0, beats} > room) beats = room[8:0];
    return beats;
  endfunction

endpackage

// File: rtl/axi_ar_burst_issuer.sv
// Pops {addr,len} read requests from the prefetch FIFO and splits them into AXI4 INCR
// bursts on the AR channel, capping outstanding bursts via R-channel last-beat completions.
module axi_ar_burst_issuer
  import araddr_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int LEN_W           = 16,
  parameter int DATA_BYTES      = 32,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 8,
  parameter int AXI_ID          = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W+LEN_W-1:0] req_data,
  input  logic                    req_vld,
  output logic                    req_en,
  output logic [3:0]              m_axi_arid,
  output logic [ADDR_W-1:0]       m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic                    rd_burst_done,
  output logic                    busy
);

  localparam int                SIZE_LOG2 = $clog2(DATA_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(DATA_BYTES - 1);

  state_t            state;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  rem;
  logic [8:0]        beats;
  logic [8:0]        beats_calc;
  logic [7:0]        outstanding;
  logic [7:0]        outstanding_nxt;
  logic              ar_hs;
  logic              room_ok;

  assign {req_addr, req_len} = req_data;
  assign ar_hs               = m_axi_arvalid & m_axi_arready;
  assign req_en              = rst_n & req_vld & (state == IDLE);
  assign busy                = (state != IDLE);
  assign m_axi_arid          = 4'(AXI_ID);
  assign m_axi_arsize        = 3'(SIZE_LOG2);
  assign m_axi_arburst       = AXI_BURST_INCR;
  assign beats_calc          = f_burst_beats(32'(rem), cur_addr[11:0], MAX_BURST, SIZE_LOG2);

  // Simultaneous issue and completion cancel; a completion with nothing outstanding is dropped.
  always_comb begin
    outstanding_nxt = outstanding;
    if (ar_hs && !rd_burst_done)
      outstanding_nxt = outstanding + 8'd1;
    else if (!ar_hs && rd_burst_done && (outstanding != 8'd0))
      outstanding_nxt = outstanding - 8'd1;
  end

  assign room_ok = (outstanding_nxt < 8'(MAX_OUTSTANDING));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) outstanding <= 8'd0;
    else        outstanding <= outstanding_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cur_addr      <= '0;
      rem           <= '0;
      beats         <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_vld) begin
            cur_addr <= req_addr & ~ADDR_MASK;
            rem      <= req_len;
            if (req_len != '0) state <= CALC;
          end
        end
        CALC: begin
          beats         <= beats_calc;
          m_axi_araddr  <= cur_addr;
          m_axi_arlen   <= 8'(beats_calc - 9'd1);
          m_axi_arvalid <= room_ok;
          state         <= ISSUE;
        end
        ISSUE: begin
          // Once raised, arvalid only drops on the handshake; the counter can only shrink meanwhile.
          if (m_axi_arvalid) begin
            if (m_axi_arready) begin
              m_axi_arvalid <= 1'b0;
              cur_addr      <= cur_addr + (ADDR_W'(beats) << SIZE_LOG2);
              rem           <= rem - LEN_W'(beats);
              state         <= (rem == LEN_W'(beats)) ? IDLE : CALC;
            end
          end else begin
            m_axi_arvalid <= room_ok;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
